// File: rtl/demux_channel_scheduler_if.sv
// Control and data signals between the channel scheduler and its controller/demux.
// The scheduler takes the slave side; the host side takes master.
interface demux_channel_scheduler_if;
   logic       start;
   logic       stop;
   logic       cont;
   logic [7:0] ch_mask;
   logic       data_in;
   logic       s0;
   logic       s1;
   logic       s2;
   logic       a;
   logic       route_en;
   logic       busy;
   logic       done;

   modport master (
      output start, stop, cont, ch_mask, data_in,
      input  s0, s1, s2, a, route_en, busy, done
   );

   modport slave (
      input  start, stop, cont, ch_mask, data_in,
      output s0, s1, s2, a, route_en, busy, done
   );
endinterface

// File: rtl/demux_channel_scheduler.sv
// Time-shares a 1:8 demux: visits each enabled channel in ascending order for DWELL
// cycles, with a one-cycle gap (data gated off) whenever the selects move.
module demux_channel_scheduler #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic                          clk,
   input logic                          rst,
   demux_channel_scheduler_if.slave     bus
);

   typedef enum logic [1:0] {StIdle, StScan, StGap, StDone} state_e;

   state_e             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         mask_q, mask_d;
   logic               cont_q, cont_d;

   logic [2:0]         lo_in, lo_q, nxt_idx;
   logic               has_next;

   function automatic logic [2:0] lowest(input logic [7:0] m);
      logic [2:0] lo;
      lo = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lo = 3'(i);
      end
      return lo;
   endfunction

   always_comb begin
      lo_in    = lowest(bus.ch_mask);
      lo_q     = lowest(mask_q);
      nxt_idx  = sel_q;
      has_next = 1'b0;
      // Descending sweep leaves the smallest enabled index above the current one.
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i] && (3'(i) > sel_q)) begin
            nxt_idx  = 3'(i);
            has_next = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start && (bus.ch_mask != 8'h00)) begin
               mask_d  = bus.ch_mask;
               cont_d  = bus.cont;
               sel_d   = lo_in;
               cnt_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.stop) begin
               state_d = StIdle;
            end else if (cnt_q == CNT_W'(DWELL - 1)) begin
               if (has_next) begin
                  sel_d   = nxt_idx;
                  state_d = StGap;
               end else if (cont_q) begin
                  sel_d   = lo_q;
                  state_d = StGap;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StGap: begin
            cnt_d = '0;
            if (bus.stop) state_d = StIdle;
            else          state_d = StScan;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= 3'd0;
         cnt_q   <= '0;
         mask_q  <= 8'h00;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
      end
   end

   assign bus.s0       = sel_q[2];
   assign bus.s1       = sel_q[1];
   assign bus.s2       = sel_q[0];
   assign bus.a        = bus.data_in & (state_q == StScan);
   assign bus.route_en = (state_q == StScan);
   assign bus.busy     = (state_q == StScan) || (state_q == StGap);
   assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_demux_channel_scheduler.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, monitors pop and compare
// whenever a scheduler is busy or pulsing done.
module tb_demux_channel_scheduler;

   typedef struct packed {
      logic [2:0] sel;
      logic       a;
      logic       route;
      logic       busy;
      logic       done;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   exp_t q0[$];
   exp_t q1[$];

   demux_channel_scheduler_if bus0 ();
   demux_channel_scheduler_if bus1 ();

   demux_channel_scheduler #(.DWELL(4), .CNT_W(8)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   demux_channel_scheduler #(.DWELL(1), .CNT_W(8)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t got_of(input logic [2:0] sel, input logic a, input logic r,
                                   input logic b, input logic d);
      exp_t g;
      g.sel = sel; g.a = a; g.route = r; g.busy = b; g.done = d;
      return g;
   endfunction

   always @(negedge clk) begin
      exp_t g, e;
      if (bus0.busy || bus0.done) begin
         g = got_of({bus0.s0, bus0.s1, bus0.s2}, bus0.a, bus0.route_en, bus0.busy, bus0.done);
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL dwell4_unexpected t=%0t got sel=%0d a=%b re=%b busy=%b done=%b",
                     $time, g.sel, g.a, g.route, g.busy, g.done);
         end else begin
            e = q0.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL dwell4_cycle t=%0t got sel=%0d a=%b re=%b busy=%b done=%b, want sel=%0d a=%b re=%b busy=%b done=%b",
                        $time, g.sel, g.a, g.route, g.busy, g.done,
                        e.sel, e.a, e.route, e.busy, e.done);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t g, e;
      if (bus1.busy || bus1.done) begin
         g = got_of({bus1.s0, bus1.s1, bus1.s2}, bus1.a, bus1.route_en, bus1.busy, bus1.done);
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL dwell1_unexpected t=%0t got sel=%0d a=%b re=%b busy=%b done=%b",
                     $time, g.sel, g.a, g.route, g.busy, g.done);
         end else begin
            e = q1.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL dwell1_cycle t=%0t got sel=%0d a=%b re=%b busy=%b done=%b, want sel=%0d a=%b re=%b busy=%b done=%b",
                        $time, g.sel, g.a, g.route, g.busy, g.done,
                        e.sel, e.a, e.route, e.busy, e.done);
            end
         end
      end
   end

   task automatic seg0(input logic [2:0] sel, input logic a, input logic r, input logic b,
                       input logic d, input int n);
      for (int i = 0; i < n; i++) q0.push_back(got_of(sel, a, r, b, d));
   endtask

   task automatic seg1(input logic [2:0] sel, input logic a, input logic r, input logic b,
                       input logic d, input int n);
      for (int i = 0; i < n; i++) q1.push_back(got_of(sel, a, r, b, d));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle0(input string name, input logic [2:0] sel);
      chk({name, "_sel"}, 32'({bus0.s0, bus0.s1, bus0.s2}), 32'(sel));
      chk({name, "_busy"}, 32'(bus0.busy), 32'd0);
      chk({name, "_done"}, 32'(bus0.done), 32'd0);
      chk({name, "_a"}, 32'(bus0.a), 32'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus0.start = 0; bus0.stop = 0; bus0.cont = 0; bus0.ch_mask = 8'h00; bus0.data_in = 1;
      bus1.start = 0; bus1.stop = 0; bus1.cont = 0; bus1.ch_mask = 8'h00; bus1.data_in = 1;
      tick(2);
      rst = 1'b0;
      idle0("reset", 3'd0);
      chk("reset_dwell1_busy", 32'(bus1.busy), 32'd0);
      chk("reset_dwell1_done", 32'(bus1.done), 32'd0);

      // Single pass over channels 0, 2, 7 with data held high.
      bus0.ch_mask = 8'b1000_0101; bus0.cont = 0; bus0.data_in = 1; bus0.start = 1;
      seg0(3'd0, 1, 1, 1, 0, 4); seg0(3'd2, 0, 0, 1, 0, 1);
      seg0(3'd2, 1, 1, 1, 0, 4); seg0(3'd7, 0, 0, 1, 0, 1);
      seg0(3'd7, 1, 1, 1, 0, 4); seg0(3'd7, 0, 0, 0, 1, 1);
      tick(1);
      bus0.start = 0;
      tick(15);
      idle0("pass_end", 3'd7);

      // Continuous on channel 4 only, stopped during cycle 7.
      bus0.ch_mask = 8'h10; bus0.cont = 1; bus0.data_in = 0; bus0.start = 1;
      seg0(3'd4, 0, 1, 1, 0, 4); seg0(3'd4, 0, 0, 1, 0, 1); seg0(3'd4, 0, 1, 1, 0, 2);
      tick(1);
      bus0.start = 0;
      tick(6);
      bus0.stop = 1;
      tick(1);
      bus0.stop = 0;
      idle0("stop", 3'd4);
      tick(3);
      chk("stop_stays_idle", 32'(bus0.busy), 32'd0);

      // Empty mask is ignored; then a scan over 1 and 6 ignores a mid-scan start.
      bus0.ch_mask = 8'h00; bus0.cont = 0; bus0.data_in = 1; bus0.start = 1;
      tick(1);
      bus0.start = 0;
      idle0("empty_mask", 3'd4);
      bus0.ch_mask = 8'b0100_0010; bus0.start = 1;
      seg0(3'd1, 1, 1, 1, 0, 4); seg0(3'd6, 0, 0, 1, 0, 1);
      seg0(3'd6, 1, 1, 1, 0, 4); seg0(3'd6, 0, 0, 0, 1, 1);
      tick(1);
      bus0.start = 0;
      tick(1);
      bus0.start = 1; bus0.ch_mask = 8'h01; bus0.cont = 1;
      tick(1);
      bus0.start = 0; bus0.cont = 0;
      tick(13);
      idle0("ignore_start", 3'd6);

      // Reset during cycle 3 of a scan, then a fresh scan over 4 and 5.
      bus0.ch_mask = 8'b0011_0000; bus0.start = 1;
      seg0(3'd4, 1, 1, 1, 0, 3);
      tick(1);
      bus0.start = 0;
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      idle0("mid_reset", 3'd0);
      bus0.start = 1;
      seg0(3'd4, 1, 1, 1, 0, 4); seg0(3'd5, 0, 0, 1, 0, 1);
      seg0(3'd5, 1, 1, 1, 0, 4); seg0(3'd5, 0, 0, 0, 1, 1);
      tick(1);
      bus0.start = 0;
      tick(10);
      idle0("restart", 3'd5);

      // DWELL=1 over all eight channels: done in cycle 16.
      bus1.ch_mask = 8'hFF; bus1.cont = 0; bus1.data_in = 1; bus1.start = 1;
      for (int k = 0; k < 8; k++) begin
         seg1(3'(k), 1, 1, 1, 0, 1);
         if (k < 7) seg1(3'(k + 1), 0, 0, 1, 0, 1);
      end
      seg1(3'd7, 0, 0, 0, 1, 1);
      tick(1);
      bus1.start = 0;
      tick(16);
      chk("dwell1_end_busy", 32'(bus1.busy), 32'd0);
      chk("dwell1_end_done", 32'(bus1.done), 32'd0);
      chk("dwell1_end_sel", 32'({bus1.s0, bus1.s1, bus1.s2}), 32'd7);

      tick(2);
      chk("dwell4_queue_drained", 32'(q0.size()), 32'd0);
      chk("dwell1_queue_drained", 32'(q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
